// File: rtl/alarm_state_ctrl_pkg.sv
// rtl/alarm_state_ctrl_pkg.sv - shared state encodings and helpers for the alarm state controller
package alarm_state_ctrl_pkg;

  // Alarm state bus encoding shared with the LED alarm display.
  typedef enum logic [1:0] {
    STATE_NORMAL    = 2'd0,
    STATE_ATTENTION = 2'd1,
    STATE_EMERGENCY = 2'd2,
    STATE_SILENCED  = 2'd3
  } state_e;

  // Sample classes, ordered by severity so they compare numerically.
  localparam logic [1:0] CLS_NORM  = 2'd0;
  localparam logic [1:0] CLS_ATTN  = 2'd1;
  localparam logic [1:0] CLS_EMERG = 2'd2;

  // Severity of a state; a silenced alarm is still an emergency underneath.
  function automatic logic [1:0] sev_of(input state_e s);
    case (s)
      STATE_NORMAL:    sev_of = CLS_NORM;
      STATE_ATTENTION: sev_of = CLS_ATTN;
      default:         sev_of = CLS_EMERG;
    endcase
  endfunction

  // State entered when escalating to a given class.
  function automatic state_e state_of(input logic [1:0] c);
    case (c)
      CLS_NORM: state_of = STATE_NORMAL;
      CLS_ATTN: state_of = STATE_ATTENTION;
      default:  state_of = STATE_EMERGENCY;
    endcase
  endfunction

endpackage

// File: rtl/alarm_state_ctrl_sync_edge.sv
// rtl/alarm_state_ctrl_sync_edge.sv - two-flop synchronizer with rising-edge pulse for raw buttons
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronize the raw input and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // One pulse per low-to-high transition, however long the input stays high.
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/alarm_state_ctrl.sv
// rtl/alarm_state_ctrl.sv - classifies sensor samples into the qualified, hysteretic alarm state
module alarm_state_ctrl
  import alarm_state_ctrl_pkg::*;
#(
  parameter logic [7:0]  ATTN_LEVEL     = 8'd60,
  parameter logic [7:0]  EMERG_LEVEL    = 8'd80,
  parameter logic [7:0]  HYST           = 8'd4,
  parameter int          QUAL_COUNT     = 4,
  parameter logic [31:0] SILENCE_CYCLES = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       ack,
  output logic [1:0] state,
  output logic       escalate
);

  localparam logic [7:0] ATTN_LOW  = ATTN_LEVEL - HYST;
  localparam logic [7:0] EMERG_LOW = EMERG_LEVEL - HYST;
  localparam logic [3:0] QUAL_TGT  = 4'(QUAL_COUNT);

  state_e      state_q, state_d;
  logic        escalate_q, escalate_d;
  logic [3:0]  qual_cnt_q, qual_cnt_d;
  logic [1:0]  run_min_q, run_min_d;
  logic [31:0] sil_timer_q, sil_timer_d;

  logic        ack_rise;
  logic [1:0]  sample_cls;
  logic [1:0]  cur_sev;
  logic        deesc;
  state_e      deesc_tgt;
  logic [3:0]  qual_inc;
  logic [1:0]  run_next;

  sync_edge u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din_i (ack),
    .rise_o(ack_rise)
  );

  // Classify the incoming sample and work out whether it de-escalates the current state.
  always_comb begin
    sample_cls = CLS_NORM;
    if (sample >= EMERG_LEVEL) begin
      sample_cls = CLS_EMERG;
    end else if (sample >= ATTN_LEVEL) begin
      sample_cls = CLS_ATTN;
    end
    cur_sev   = sev_of(state_q);
    deesc     = 1'b0;
    deesc_tgt = STATE_NORMAL;
    if (cur_sev == CLS_EMERG) begin
      if (sample < ATTN_LOW) begin
        deesc = 1'b1;
      end else if (sample < EMERG_LOW) begin
        deesc     = 1'b1;
        deesc_tgt = STATE_ATTENTION;
      end
    end else if (cur_sev == CLS_ATTN) begin
      deesc = (sample < ATTN_LOW);
    end
    qual_inc = qual_cnt_q + 4'd1;
    run_next = (qual_cnt_q == 4'd0 || sample_cls < run_min_q) ? sample_cls : run_min_q;
  end

  // Next state: de-escalation wins, then escalation, then ack/silence timing.
  always_comb begin
    state_d     = state_q;
    escalate_d  = 1'b0;
    qual_cnt_d  = qual_cnt_q;
    run_min_d   = run_min_q;
    sil_timer_d = sil_timer_q;

    if (sample_valid && deesc) begin
      state_d     = deesc_tgt;
      qual_cnt_d  = 4'd0;
      run_min_d   = CLS_EMERG;
      sil_timer_d = 32'd0;
    end else begin
      if (sample_valid) begin
        if (sample_cls > cur_sev) begin
          if (qual_inc == QUAL_TGT) begin
            state_d    = state_of(run_next);
            escalate_d = 1'b1;
            qual_cnt_d = 4'd0;
            run_min_d  = CLS_EMERG;
          end else begin
            qual_cnt_d = qual_inc;
            run_min_d  = run_next;
          end
        end else begin
          qual_cnt_d = 4'd0;
          run_min_d  = CLS_EMERG;
        end
      end
      // Escalation only happens below EMERGENCY, where ack and the timer are inert.
      case (state_q)
        STATE_EMERGENCY: begin
          if (ack_rise) begin
            state_d     = STATE_SILENCED;
            sil_timer_d = SILENCE_CYCLES - 32'd1;
          end
        end
        STATE_SILENCED: begin
          if (sil_timer_q == 32'd0) begin
            state_d = STATE_EMERGENCY;
          end else begin
            sil_timer_d = sil_timer_q - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_NORMAL;
      escalate_q  <= 1'b0;
      qual_cnt_q  <= 4'd0;
      run_min_q   <= CLS_EMERG;
      sil_timer_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      escalate_q  <= escalate_d;
      qual_cnt_q  <= qual_cnt_d;
      run_min_q   <= run_min_d;
      sil_timer_q <= sil_timer_d;
    end
  end

  assign state    = state_q;
  assign escalate = escalate_q;

endmodule

// File: doc/alarm_state_ctrl.md
# alarm_state_ctrl

Alarm state controller. It classifies a stream of 8-bit sensor samples into the 2-bit alarm `state` consumed by the LED alarm display. It applies consecutive-sample qualification on escalation and hysteresis on de-escalation. It also provides a user acknowledge that silences an emergency for a bounded time. It is the producer side of the `state` bus: it sits between the sensor sampling logic and the alarm LED driver.

## Interface
- `ATTN_LEVEL`, default 8'd60: sample ≥ this classifies as ATTENTION.
- `EMERG_LEVEL`, default 8'd80: sample ≥ this classifies as EMERGENCY. Must be > `ATTN_LEVEL`.
- `HYST`, default 8'd4: de-escalation margin. Must be ≤ `ATTN_LEVEL`.
- `QUAL_COUNT`, default 4: consecutive qualifying samples required to escalate. Range 1..15.
- `SILENCE_CYCLES`, default 32'd50_000_000: silence duration in clk cycles. Must be ≥ 1.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sample`, in, 8: unsigned sensor reading.
- `sample_valid`, in, 1: `sample` is accepted on each rising edge where this is high. No backpressure.
- `ack`, in, 1: raw, asynchronous acknowledge button, active-high.
- `state`, out, 2: `STATE_NORMAL`, `STATE_ATTENTION`, `STATE_EMERGENCY` or `STATE_SILENCED`. Registered.
- `escalate`, out, 1: one-cycle pulse on each transition to a higher severity. Registered.

## Operation
- Sample class: EMERG if `sample` ≥ `EMERG_LEVEL`; otherwise ATTN if `sample` ≥ `ATTN_LEVEL`; otherwise NORM.
- Severity order is NORMAL < ATTENTION < EMERGENCY. SILENCED counts as EMERGENCY for classification.
- **Escalation.**
  - A valid sample whose class exceeds current severity increments `qual_cnt` and updates `run_min` to the minimum class seen in the current run.
  - When the increment reaches `QUAL_COUNT`, `state` takes `run_min`, `escalate` pulses, and `qual_cnt` clears.
  - Any valid sample not above current severity clears `qual_cnt`. Cycles without `sample_valid` hold `qual_cnt`.
- **De-escalation** takes effect on a single valid sample, with no qualification:
  - From EMERGENCY or SILENCED: `sample` < `ATTN_LEVEL-HYST` goes to NORMAL. Otherwise `sample` < `EMERG_LEVEL-HYST` goes to ATTENTION.
  - From ATTENTION: `sample` < `ATTN_LEVEL-HYST` goes to NORMAL.
  - Samples inside the hysteresis band hold `state`.
- **Acknowledge.**
  - `ack` passes through a 2-flop synchronizer and a rising-edge detector.
  - An edge in EMERGENCY goes to SILENCED and loads `sil_timer` = `SILENCE_CYCLES-1`. Ack edges in any other state are ignored.
  - In SILENCED, `sil_timer` decrements every cycle. At 0 the next edge returns to EMERGENCY; `escalate` does not pulse.
  - Holding `ack` high produces only one edge.
- **Simultaneous events.**
  - A de-escalating sample overrides an ack edge, a timer expiry, and escalation.
  - In EMERGENCY, an ack edge together with a non-de-escalating sample goes to SILENCED.
  - `qual_cnt` is always 0 in EMERGENCY and SILENCED.
- **Reset**, asserted at any time: `state`=NORMAL, `escalate`=0, `qual_cnt`=0, `run_min`=EMERG, `sil_timer`=0, synchronizer flops=0.

## Timing
- Sample-to-state latency is 1 cycle: `state` reflects a sample accepted on edge k from edge k onward, so it is visible after edge k.
- `escalate` is high for exactly the cycle after the edge where `state` increases.
- Ack latency: with `ack` high before edge k, `state` reads SILENCED after edge k+2 (synchronizer 2 edges plus register).
- Silence duration: exactly `SILENCE_CYCLES` cycles in SILENCED before EMERGENCY reappears.
- Compares use 8-bit unsigned arithmetic. `ATTN_LEVEL-HYST` and `EMERG_LEVEL-HYST` are constants with no underflow, guaranteed by the parameter rules.
- `qual_cnt` is 4 bits. `sil_timer` is 32 bits.

## Structure
- `STATE_NORMAL`=2'd0, `STATE_ATTENTION`=2'd1, `STATE_EMERGENCY`=2'd2 and `STATE_SILENCED`=2'd3 live in `constants.h`; add `STATE_SILENCED` there.
- The LED driver shows nothing for SILENCED.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge pulse, with `clk` and `rst_n`. It is reused for future buttons.

## Test plan
- Defaults, 4 valid samples of 65 → `state`=ATTENTION after the 4th, `escalate` high 1 cycle. 3 samples of 65 then 50 → `state` stays NORMAL.
- From NORMAL, samples 85, 85, 70, 90 → `state`=ATTENTION (`run_min`); then 4 samples of 90 → EMERGENCY.
- In EMERGENCY: sample 78 → holds; sample 75 → ATTENTION; sample 55 from EMERGENCY → NORMAL directly.
- EMERGENCY, `SILENCE_CYCLES`=10, ack high 20 cycles → SILENCED after 3 edges; EMERGENCY returns exactly 10 cycles later; no second silence.
- Ack edge and a sample of 50 on the same cycle in EMERGENCY → NORMAL, not SILENCED. Ack in ATTENTION → no change.
- Assert `rst_n` low mid-silence and mid-qualification → `state`=NORMAL and `escalate`=0 immediately; after release, 3 samples of 65 do not escalate.
